// File: rtl/slowfil_pkg.sv
// Shared definitions for the multi-channel slow FIR: FSM encoding and the
// end-to-end latency from sample acceptance to o_ce.
package slowfil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Accept cycle, memory read, product register and output register.
  localparam int PIPE_STAGES = 4;

  function automatic int slowfil_latency(input int ntaps);
    return ntaps + PIPE_STAGES;
  endfunction

endpackage

// File: rtl/slowfil_tapmem.sv
// Coefficient store shared by all channels: sequential loader with a
// wrapping write index and a registered read port.
module slowfil_tapmem
  import slowfil_pkg::*;
#(
  parameter int LGNTAPS    = 7,
  parameter int TW         = 16,
  parameter int FIXED_TAPS = 0,
  parameter     INITIAL_COEFFS = ""
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [TW-1:0]      i_tap,
  input  logic [LGNTAPS-1:0] i_raddr,
  output logic [TW-1:0]      o_tap
);

  localparam int MEMSZ = 1 << LGNTAPS;

  logic [TW-1:0]      mem [0:MEMSZ-1];
  logic [LGNTAPS-1:0] twidx_r;
  logic               wr_s;

  assign wr_s = (FIXED_TAPS == 0) && i_wr && !i_reset;

  // Write index: advances once per accepted coefficient write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      twidx_r <= '0;
    end else if (wr_s) begin
      twidx_r <= twidx_r + LGNTAPS'(1);
    end else begin
      twidx_r <= twidx_r;
    end
  end

  // Storage and registered read, aligned with the data memory read.
  always_ff @(posedge i_clk) begin
    if (wr_s) begin
      mem[twidx_r] <= i_tap;
    end
    o_tap <= mem[i_raddr];
  end

endmodule

// File: rtl/slowfil_mc.sv
// Time-multiplexed FIR: NCHAN sample streams share one tap set, one
// multiplier and one accumulator; each channel keeps a circular history.
module slowfil_mc
  import slowfil_pkg::*;
#(
  parameter int LGNTAPS    = 7,
  parameter int NTAPS      = 110,
  parameter int LGCHAN     = 2,
  parameter int IW         = 16,
  parameter int TW         = 16,
  parameter int OW         = IW + TW + LGNTAPS,
  parameter int FIXED_TAPS = 0,
  parameter     INITIAL_COEFFS = ""
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tap_wr,
  input  logic [TW-1:0]     i_tap,
  input  logic              i_ce,
  input  logic [LGCHAN-1:0] i_chan,
  input  logic [IW-1:0]     i_sample,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_ce,
  output logic [LGCHAN-1:0] o_chan,
  output logic [OW-1:0]     o_result
);

  localparam int MEMSZ = 1 << LGNTAPS;
  localparam int NCHAN = 1 << LGCHAN;
  localparam int CW    = LGNTAPS + 2;
  localparam int PW    = IW + TW;
  localparam int DRAIN = slowfil_latency(NTAPS) - NTAPS - 1;

  logic [IW-1:0]       dmem [0:NCHAN*MEMSZ-1];
  logic [LGNTAPS-1:0]  widx_r [0:NCHAN-1];
  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [LGCHAN-1:0]   chan_r;
  logic [LGNTAPS-1:0]  base_r;
  logic                accept_s, issue_s;
  logic [LGNTAPS-1:0]  tidx_s, didx_s;
  logic [TW-1:0]       tap_q_s;
  logic signed [IW-1:0] data_r;
  logic                rd_vld_r, rd_first_r, rd_last_r;
  logic signed [PW-1:0] prod_r;
  logic                prod_vld_r, prod_first_r, prod_last_r;
  logic signed [OW-1:0] acc_r;
  logic                acc_done_r;

  assign accept_s = i_ce && !o_busy && !i_reset;
  assign tidx_s   = cnt_r[LGNTAPS-1:0];
  // Newest sample sits at base_r; tap k pairs with the sample k steps older.
  assign didx_s   = base_r - tidx_s;

  slowfil_tapmem #(
    .LGNTAPS(LGNTAPS), .TW(TW), .FIXED_TAPS(FIXED_TAPS),
    .INITIAL_COEFFS(INITIAL_COEFFS)
  ) u_tapmem (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_wr   (i_tap_wr && !o_busy),
    .i_tap  (i_tap),
    .i_raddr(tidx_s),
    .o_tap  (tap_q_s)
  );

  // Next-state and tap-issue decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_s = 1'b1;
        if (cnt_r == CW'(NTAPS - 1)) begin
          state_s = ST_FLUSH;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_r == CW'(DRAIN - 1)) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Control state, channel indices, pipeline tags and outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
      o_ce         <= 1'b0;
      o_chan       <= '0;
      o_result     <= '0;
      chan_r       <= '0;
      base_r       <= '0;
      rd_vld_r     <= 1'b0;
      rd_first_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      prod_last_r  <= 1'b0;
      acc_done_r   <= 1'b0;
      for (int c = 0; c < NCHAN; c++) widx_r[c] <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      o_busy  <= (state_s != ST_IDLE);
      if (i_ce && o_busy) o_overrun <= 1'b1;
      if (accept_s) begin
        chan_r         <= i_chan;
        base_r         <= widx_r[i_chan];
        widx_r[i_chan] <= widx_r[i_chan] + LGNTAPS'(1);
      end
      rd_vld_r     <= issue_s;
      rd_first_r   <= issue_s && (cnt_r == CW'(0));
      rd_last_r    <= issue_s && (cnt_r == CW'(NTAPS - 1));
      prod_vld_r   <= rd_vld_r;
      prod_first_r <= rd_first_r;
      prod_last_r  <= rd_last_r;
      acc_done_r   <= prod_vld_r && prod_last_r;
      o_ce         <= acc_done_r;
      if (acc_done_r) begin
        o_result <= acc_r;
        o_chan   <= chan_r;
      end
    end
  end

  // Data memory and MAC datapath; sample history survives reset.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      dmem[{i_chan, widx_r[i_chan]}] <= i_sample;
    end
    data_r <= dmem[{chan_r, didx_s}];
    prod_r <= PW'(data_r) * PW'($signed(tap_q_s));
    if (prod_vld_r) begin
      acc_r <= prod_first_r ? OW'(prod_r) : acc_r + OW'(prod_r);
    end
  end

endmodule

// File: tb/tb_slowfil_mc.sv
// Self-checking bench for slowfil_mc with a small tap set and two channels,
// compared against a per-channel history-queue reference model.
module tb_slowfil_mc;

  localparam int LGNTAPS = 2, NTAPS = 4, LGCHAN = 1, IW = 8, TW = 8;
  localparam int OW = IW + TW + LGNTAPS;
  localparam int LAT = NTAPS + 4;

  logic              i_clk = 1'b0;
  logic              i_reset, i_tap_wr, i_ce;
  logic [TW-1:0]     i_tap;
  logic [LGCHAN-1:0] i_chan;
  logic [IW-1:0]     i_sample;
  logic              o_busy, o_overrun, o_ce;
  logic [LGCHAN-1:0] o_chan;
  logic [OW-1:0]     o_result;

  int checks = 0;
  int errors = 0;
  int taps_m [NTAPS];
  int hist [2][$];

  always #5 i_clk = ~i_clk;

  slowfil_mc #(
    .LGNTAPS(LGNTAPS), .NTAPS(NTAPS), .LGCHAN(LGCHAN), .IW(IW), .TW(TW),
    .OW(OW), .FIXED_TAPS(0), .INITIAL_COEFFS("")
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tap_wr(i_tap_wr), .i_tap(i_tap),
    .i_ce(i_ce), .i_chan(i_chan), .i_sample(i_sample),
    .o_busy(o_busy), .o_overrun(o_overrun), .o_ce(o_ce),
    .o_chan(o_chan), .o_result(o_result)
  );

  function automatic logic [OW-1:0] model_out(input int ch);
    int s;
    s = 0;
    for (int k = 0; k < NTAPS; k++)
      if (k < hist[ch].size()) s += taps_m[k] * hist[ch][k];
    return s[OW-1:0];
  endfunction

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_taps(input int t [NTAPS]);
    for (int k = 0; k < NTAPS; k++) begin
      i_tap_wr = 1'b1;
      i_tap    = t[k][TW-1:0];
      taps_m[k] = t[k];
      step();
    end
    i_tap_wr = 1'b0;
  endtask

  // Offers one sample while idle, then waits (bounded) for its result.
  task automatic do_sample(input int ch, input int s, output int lat,
                           output logic [OW-1:0] res, output int och,
                           output logic busy1);
    i_chan   = ch[LGCHAN-1:0];
    i_sample = s[IW-1:0];
    i_ce     = 1'b1;
    step();
    i_ce = 1'b0;
    hist[ch].push_front(s);
    busy1 = o_busy;
    lat   = 1;
    while (o_ce !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    res = o_result;
    och = int'(o_chan);
  endtask

  task automatic prime;
    int lat, och;
    logic [OW-1:0] res;
    logic b;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < NTAPS; k++) do_sample(c, 0, lat, res, och, b);
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_ce = 1'b0; i_tap_wr = 1'b0; i_tap = '0;
    i_chan = '0; i_sample = '0;
    repeat (3) step();
    i_reset = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", o_ce); end
    checks++; if (o_chan !== '0) begin errors++; $display("FAIL reset_chan got %0d want 0", o_chan); end
    checks++; if (o_result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", o_result); end
  endtask

  task automatic test_impulse;
    int stim [5] = '{1, 0, 0, 0, 0};
    int want [5] = '{1, 2, 3, 4, 0};
    int lat, och, w;
    logic [OW-1:0] res, e;
    logic b;
    for (int i = 0; i < 5; i++) begin
      do_sample(0, stim[i], lat, res, och, b);
      e = model_out(0);
      w = want[i];
      checks++; if (res !== e || res !== w[OW-1:0]) begin errors++; $display("FAIL impulse_result[%0d] got %0d want %0d", i, $signed(res), w); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL impulse_latency[%0d] got %0d want %0d", i, lat, LAT); end
      checks++; if (och !== 0) begin errors++; $display("FAIL impulse_chan[%0d] got %0d want 0", i, och); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL impulse_busy[%0d] got %b want 1", i, b); end
    end
  endtask

  task automatic test_interleave;
    int lat, och, w;
    logic [OW-1:0] res, e;
    logic b;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        do_sample(c, (r == 0) ? ((c == 0) ? 1 : 10) : 0, lat, res, och, b);
        e = model_out(c);
        w = (c == 0) ? (r + 1) : 10 * (r + 1);
        checks++; if (res !== e || res !== w[OW-1:0]) begin errors++; $display("FAIL interleave_result ch%0d r%0d got %0d want %0d", c, r, $signed(res), w); end
        checks++; if (och !== c) begin errors++; $display("FAIL interleave_chan r%0d got %0d want %0d", r, och, c); end
      end
    end
    repeat (3) step();
    checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL ce_pulse got %b want 0", o_ce); end
    checks++; if (o_result !== OW'(40)) begin errors++; $display("FAIL result_hold got %0d want 40", o_result); end
  endtask

  task automatic test_overrun;
    int lat, och;
    logic [OW-1:0] res, e;
    logic b;
    i_chan = 1'b0; i_sample = 8'd5; i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    hist[0].push_front(5);
    repeat (2) step();
    i_chan = 1'b0; i_sample = 8'd77; i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", o_overrun); end
    lat = 4;
    while (o_ce !== 1'b1 && lat < 40) begin step(); lat++; end
    e = model_out(0);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL overrun_latency got %0d want %0d", lat, LAT); end
    checks++; if (o_result !== e) begin errors++; $display("FAIL overrun_result got %0d want %0d", $signed(o_result), $signed(e)); end
    do_sample(0, 0, lat, res, och, b);
    e = model_out(0);
    checks++; if (res !== e) begin errors++; $display("FAIL overrun_dropped got %0d want %0d", $signed(res), $signed(e)); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", o_overrun); end
  endtask

  task automatic test_extremes;
    int t [NTAPS] = '{-128, -128, -128, -128};
    int r [NTAPS] = '{1, 2, 3, 4};
    int lat, och;
    logic [OW-1:0] res, e, big;
    logic b;
    big = OW'(65536);
    load_taps(t);
    for (int i = 0; i < NTAPS; i++) begin
      do_sample(1, -128, lat, res, och, b);
      e = model_out(1);
      checks++; if (res !== e) begin errors++; $display("FAIL extreme_result[%0d] got %0d want %0d", i, $signed(res), $signed(e)); end
    end
    checks++; if (res !== big) begin errors++; $display("FAIL extreme_full got %0d want 65536", $signed(res)); end
    load_taps(r);
  endtask

  task automatic test_reset_mid;
    int lat, och;
    logic [OW-1:0] res, e;
    logic b, seen;
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_held got %b want 1", o_overrun); end
    i_chan = 1'b0; i_sample = 8'd3; i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    repeat (3) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", o_busy); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got %b want 0", o_overrun); end
    seen = o_ce;
    repeat (20) begin step(); if (o_ce === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_ce got %b want 0", seen); end
    hist[0].delete(); hist[1].delete();
    prime();
    for (int i = 0; i < NTAPS; i++) begin
      do_sample(1, (i == 0) ? 1 : 0, lat, res, och, b);
      e = model_out(1);
      checks++; if (res !== e || lat !== LAT || och !== 1) begin errors++; $display("FAIL post_reset[%0d] got %0d/%0d/ch%0d want %0d/%0d/ch1", i, $signed(res), lat, och, $signed(e), LAT); end
    end
  endtask

  task automatic test_tap_wr_busy;
    int t [NTAPS] = '{5, 6, 7, 8};
    int lat, och;
    logic [OW-1:0] res, e;
    logic b;
    i_chan = 1'b0; i_sample = 8'd1; i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    hist[0].push_front(1);
    i_tap_wr = 1'b1; i_tap = 8'd99;
    repeat (2) step();
    i_tap_wr = 1'b0;
    lat = 3;
    while (o_ce !== 1'b1 && lat < 40) begin step(); lat++; end
    e = model_out(0);
    checks++; if (o_result !== e) begin errors++; $display("FAIL busy_tapwr got %0d want %0d", $signed(o_result), $signed(e)); end
    load_taps(t);
    for (int i = 0; i < NTAPS; i++) begin
      do_sample(0, (i == 0) ? 1 : 0, lat, res, och, b);
      e = model_out(0);
      checks++; if (res !== e) begin errors++; $display("FAIL tap_index[%0d] got %0d want %0d", i, $signed(res), $signed(e)); end
    end
  endtask

  task automatic test_random;
    int t [NTAPS];
    int lat, och, ch, s;
    logic [OW-1:0] res, e;
    logic b;
    for (int k = 0; k < NTAPS; k++) t[k] = int'($urandom_range(255, 0)) - 128;
    load_taps(t);
    for (int i = 0; i < 24; i++) begin
      ch = int'($urandom_range(1, 0));
      s  = int'($urandom_range(255, 0)) - 128;
      do_sample(ch, s, lat, res, och, b);
      e = model_out(ch);
      checks++; if (res !== e || och !== ch || lat !== LAT) begin errors++; $display("FAIL random[%0d] got %0d/ch%0d/%0d want %0d/ch%0d/%0d", i, $signed(res), och, lat, $signed(e), ch, LAT); end
      repeat ($urandom_range(2, 0)) step();
    end
  endtask

  initial begin
    int t0 [NTAPS] = '{1, 2, 3, 4};
    test_reset();
    load_taps(t0);
    prime();
    test_impulse();
    test_interleave();
    test_overrun();
    test_extremes();
    test_reset_mid();
    test_tap_wr_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
